// File: rtl/reg_file_seq_pkg.sv
// Shared opcodes, FSM encoding and default sizes for the register-file sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
package reg_file_seq_pkg;

    localparam int DEF_WIDTH  = 9;
    localparam int DEF_ADDR_W = 2;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/reg_file_seq_alu.sv
// Combinational ALU for the sequencer: op/A/B/imm -> {carry, result}. REG_FILE_SEQ_SAT_EN makes ADD/SUB saturate.
// Latency: 0 cycles (pure combinational). Backpressure: none.
module seq_alu
    import reg_file_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] out;

    always_comb begin
        sum  = {1'b0, a_i} + {1'b0, b_i};
        // Top bit of the zero-extended difference is the borrow (A < B).
        diff = {1'b0, a_i} - {1'b0, b_i};
        out  = '0;
        case (op_i)
            OP_LDI: out = {1'b0, imm_i};
            OP_MOV: out = {1'b0, a_i};
`ifdef REG_FILE_SEQ_SAT_EN
            OP_ADD: out = sum[WIDTH]  ? {1'b1, {WIDTH{1'b1}}} : sum;
            OP_SUB: out = diff[WIDTH] ? {1'b1, {WIDTH{1'b0}}} : diff;
`else
            OP_ADD: out = sum;
            OP_SUB: out = diff;
`endif
            OP_AND: out = {1'b0, a_i & b_i};
            OP_OR:  out = {1'b0, a_i | b_i};
            OP_XOR: out = {1'b0, a_i ^ b_i};
            default: out = '0;
        endcase
    end

    assign res_o   = out[WIDTH-1:0];
    assign carry_o = out[WIDTH];

endmodule

// File: rtl/reg_file_seq.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) driving a 4x9 register file; optional macro REG_FILE_SEQ_SAT_EN.
// Latency: write/done in the 3rd cycle after the handshake cycle. Backpressure: in_ready high only in IDLE.
module reg_file_seq
    import reg_file_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [ADDR_W-1:0] in_src0,
    input  logic [ADDR_W-1:0] in_src1,
    input  logic [WIDTH-1:0]  in_imm,
    output logic [ADDR_W-1:0] rf_rd0_addr,
    output logic [ADDR_W-1:0] rf_rd1_addr,
    input  logic [WIDTH-1:0]  rf_rd0_data,
    input  logic [WIDTH-1:0]  rf_rd1_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [WIDTH-1:0]  rf_wr_data,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              carry,
    output logic              zero
);

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] dst_q, src0_q, src1_q;
    logic [WIDTH-1:0]  imm_q, a_q, b_q, result_q;
    logic              carry_q, zero_q, wr_en_q, done_q;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_carry;

    seq_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i    (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .imm_i   (imm_q),
        .res_o   (alu_res),
        .carry_o (alu_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_NOP;
            dst_q    <= '0;
            src0_q   <= '0;
            src1_q   <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= in_op;
                        dst_q  <= in_dst;
                        src0_q <= in_src0;
                        src1_q <= in_src1;
                        imm_q  <= in_imm;
                    end
                end
                S_READ: begin
                    a_q <= rf_rd0_data;
                    b_q <= rf_rd1_data;
                end
                S_EXEC: begin
                    // NOP retires but leaves the flags and the register file untouched.
                    if (op_q != OP_NOP) begin
                        result_q <= alu_res;
                        carry_q  <= alu_carry;
                        zero_q   <= (alu_res == '0);
                        wr_en_q  <= 1'b1;
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign rf_rd0_addr = src0_q;
    assign rf_rd1_addr = src1_q;
    assign rf_wr_en    = wr_en_q;
    assign rf_wr_addr  = dst_q;
    assign rf_wr_data  = result_q;
    assign done        = done_q;
    assign result      = result_q;
    assign carry       = carry_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_reg_file_seq.sv
// Bench for reg_file_seq: behavioural register file, reference model and a queue of expected retirements.
module tb_reg_file_seq;

    localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, MOV = 3'd2, ADD = 3'd3,
                           SUB = 3'd4, AND_ = 3'd5, OR_ = 3'd6, XOR_ = 3'd7;

    typedef struct {
        int         hs;
        logic       we;
        logic [1:0] addr;
        logic [8:0] res;
        logic       c;
        logic       z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'd0;
    logic [1:0] in_dst = 2'd0, in_src0 = 2'd0, in_src1 = 2'd0;
    logic [8:0] in_imm = 9'd0;
    logic [1:0] rf_rd0_addr, rf_rd1_addr, rf_wr_addr;
    logic [8:0] rf_rd0_data, rf_rd1_data, rf_wr_data, result;
    logic       rf_wr_en, done, carry, zero;

    logic [8:0] rf [4] = '{default: 9'd0};
    logic [8:0] mdl [4];
    logic [8:0] m_res;
    logic       m_c, m_z;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_chk = 0, n_pass = 0, n_done = 0, n_sent = 0;
    logic       post_pend = 1'b0;
    logic [1:0] post_addr;
    logic [8:0] post_val;

    always #5 clk = ~clk;

    reg_file_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_src0(in_src0), .in_src1(in_src1), .in_imm(in_imm),
        .rf_rd0_addr(rf_rd0_addr), .rf_rd1_addr(rf_rd1_addr),
        .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .done(done), .result(result), .carry(carry), .zero(zero)
    );

    assign rf_rd0_data = rf[rf_rd0_addr];
    assign rf_rd1_data = rf[rf_rd1_addr];
    always @(posedge clk) if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: computes the retirement expected for one instruction.
    task automatic push(input logic [2:0] op, input logic [1:0] d, s0, s1, input logic [8:0] imm);
        exp_t       e;
        int         a, b;
        logic [8:0] r;
        logic       c;
        a = int'(mdl[s0]);
        b = int'(mdl[s1]);
        r = 9'd0;
        c = 1'b0;
        case (op)
            LDI:  r = imm;
            MOV:  r = mdl[s0];
            ADD: begin
                if (a + b > 511) begin
                    c = 1'b1;
`ifdef REG_FILE_SEQ_SAT_EN
                    r = 9'h1FF;
`else
                    r = 9'(a + b - 512);
`endif
                end else r = 9'(a + b);
            end
            SUB: begin
                if (a < b) begin
                    c = 1'b1;
`ifdef REG_FILE_SEQ_SAT_EN
                    r = 9'h000;
`else
                    r = 9'(a + 512 - b);
`endif
                end else r = 9'(a - b);
            end
            AND_: r = mdl[s0] & mdl[s1];
            OR_:  r = mdl[s0] | mdl[s1];
            XOR_: r = mdl[s0] ^ mdl[s1];
            default: ;
        endcase
        e.hs   = cyc;
        e.we   = (op != NOP);
        e.addr = d;
        if (e.we) begin
            mdl[d] = r;
            m_res  = r;
            m_c    = c;
            m_z    = (r == 9'd0);
        end
        e.res = m_res;
        e.c   = m_c;
        e.z   = m_z;
        exp_q.push_back(e);
        n_sent++;
    endtask

    // Called on a negedge; returns on the negedge where in_ready is back.
    task automatic send(input logic [2:0] op, input logic [1:0] d, s0, s1,
                        input logic [8:0] imm, input bit hold);
        int w = 0;
        in_op = op; in_dst = d; in_src0 = s0; in_src1 = s1; in_imm = imm;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept", 32'(in_ready), 1);
        if (in_ready) begin
            push(op, d, s0, s1, imm);
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                chk("in_ready_busy", 32'(in_ready), 0);
            end
            @(negedge clk);
            chk("in_ready_back", 32'(in_ready), 1);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (post_pend) begin
                chk("rf_readback", 32'(rf[post_addr]), 32'(post_val));
                post_pend = 1'b0;
            end
            if (done) begin
                if (exp_q.size() == 0) chk("done_unexpected", 32'(done), 0);
                else begin
                    mon_e = exp_q.pop_front();
                    n_done++;
                    chk("latency", 32'(cyc - mon_e.hs), 3);
                    chk("wr_en", 32'(rf_wr_en), 32'(mon_e.we));
                    if (mon_e.we) begin
                        chk("wr_addr", 32'(rf_wr_addr), 32'(mon_e.addr));
                        chk("wr_data", 32'(rf_wr_data), 32'(mon_e.res));
                        post_pend = 1'b1;
                        post_addr = mon_e.addr;
                        post_val  = mon_e.res;
                    end
                    chk("result", 32'(result), 32'(mon_e.res));
                    chk("carry", 32'(carry), 32'(mon_e.c));
                    chk("zero", 32'(zero), 32'(mon_e.z));
                end
            end else if (rf_wr_en) begin
                chk("wr_en_stray", 32'(rf_wr_en), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) mdl[i] = 9'd0;
        m_res = 9'd0; m_c = 1'b0; m_z = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_wr_en", 32'(rf_wr_en), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", 32'({carry, zero}), 0);
        chk("rst_addrs", 32'({rf_rd0_addr, rf_rd1_addr, rf_wr_addr}), 0);
        chk("rst_wr_data", 32'(rf_wr_data), 0);

        @(negedge clk);
        send(LDI, 2'd1, 2'd0, 2'd0, 9'h00A, 1'b0);
        send(LDI, 2'd2, 2'd0, 2'd0, 9'h005, 1'b0);
        send(ADD, 2'd3, 2'd1, 2'd2, 9'h000, 1'b0);
        send(LDI, 2'd0, 2'd0, 2'd0, 9'h1FF, 1'b0);
        send(ADD, 2'd0, 2'd0, 2'd1, 9'h000, 1'b0);
        send(SUB, 2'd3, 2'd2, 2'd1, 9'h000, 1'b0);
        send(XOR_, 2'd1, 2'd1, 2'd1, 9'h000, 1'b0);
        send(ADD, 2'd2, 2'd2, 2'd0, 9'h000, 1'b0);
        send(NOP, 2'd3, 2'd0, 2'd0, 9'h0AA, 1'b0);

        // Reset while the instruction sits in EXEC: it must vanish without a write.
        in_op = LDI; in_dst = 2'd3; in_imm = 9'h055; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(rf_wr_en), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_result", 32'(result), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_res = 9'd0; m_c = 1'b0; m_z = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("midrst_no_write", 32'({rf_wr_en, done}), 0);
            @(negedge clk);
        end
        chk("midrst_rf3", 32'(rf[3]), 32'(mdl[3]));
        chk("midrst_idle", 32'(in_ready), 1);

        for (int n = 0; n < 8; n++) begin
            send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)), 1'b1);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        chk("queue_empty", 32'(exp_q.size()), 0);
        chk("done_count", 32'(n_done), 32'(n_sent));
        for (int i = 0; i < 4; i++) chk("final_rf", 32'(rf[i]), 32'(mdl[i]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
